mem_ctrl: RTL
=============

# mem_ctrl

Arbiter and sequencer for the single byte-wide RAM port. It shares the port between the instruction fetcher, which fills the instruction queue with 32-bit words, and the load/store buffer, which issues 1/2/4-byte loads and stores. It serializes each multi-byte access into per-byte RAM cycles, assembles read data, and honours pipeline flush (`roll`) and the IO write back-pressure.

## Interface
- No parameters. Constants come from `define.v`: `IO_BASE`=32'h30000, `IO_MASK`=32'hFFFF0000.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active-low
- rdy  in  1  global enable; low freezes every register
- roll  in  1  misprediction flush
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  IO write buffer full
- IF_req  in  1  fetch request; level, held with IF_addr until IF_done
- IF_addr  in  32  fetch address
- IF_done  out  1  one-cycle pulse; IF_inst valid
- IF_inst  out  32  fetched word, little-endian
- LSB_req  in  1  load/store request; level, operands held until LSB_done
- LSB_wr  in  1  1 = store
- LSB_len  in  2  00 = 1 B, 01 = 2 B, 11 = 4 B; 10 is illegal
- LSB_addr  in  32  base byte address
- LSB_data  in  32  store data; low bytes used
- LSB_done  out  1  one-cycle pulse
- LSB_rdata  out  32  load data, zero-extended; sign extension belongs to the LSB

## Operation
- States:
  - IDLE
  - IF_RD: 4 bytes
  - LS_RD: n bytes
  - LS_WR: n bytes
- Byte counter `cnt` runs 0..n, 3 bits. n = LSB_len+1, so 1, 2 or 4.
- All outputs are registered.
- Reset values:
  - state = IDLE, cnt = 0, last_grant = IF
  - mem_a = 0, mem_dout = 0, mem_wr = 0
  - IF_done = 0, LSB_done = 0, IF_inst = 0, LSB_rdata = 0
- Requests are sampled only at the end of IDLE cycles.
- Arbitration is round-robin.
  - Only one requester: it wins.
  - Both requesting: the one not equal to last_grant wins.
  - last_grant updates on each grant; its reset value makes LSB win the first tie.
- IF_RD/LS_RD:
  - Drive mem_a = base+i with mem_wr = 0 for i = 0..n-1.
  - Capture mem_din into byte i of the result one cycle after address i is driven.
  - After the final capture, pulse done and return to IDLE.
- LS_WR:
  - Drive mem_a = base+i, mem_dout = data[8i+7:8i], mem_wr = 1 for each byte.
  - If `(LSB_addr & IO_MASK) == IO_BASE` and io_buffer_full = 1: hold the byte with mem_wr = 0 and do not advance cnt.
  - After the last byte, pulse LSB_done and return to IDLE.
- Outside LS_WR issue cycles: mem_wr = 0.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- roll = 1 at a clock edge, in IDLE, IF_RD or LS_RD:
  - Next state IDLE, cnt = 0, mem_wr = 0.
  - No done pulse is issued.
  - IF_req, and LSB_req with LSB_wr = 0, sampled in that cycle are ignored.
- roll in LS_WR does not abort the write. The store is already committed and completes normally with its LSB_done pulse.
- roll in the done cycle suppresses nothing; the pulse still fires.
- rdy = 0: state, counters and outputs hold. The environment keeps the RAM idle.
- rst_n low: immediate return to reset values, including mid-transaction; no done pulse.

## Timing
- Request sampled at the end of IDLE cycle t.
- Read of n bytes:
  - Addresses driven in cycles t+1..t+n.
  - Byte i captured at the end of cycle t+2+i.
  - Done and data visible in cycle t+n+2. A fetch therefore completes in t+6.
- Write of n bytes, no IO stall:
  - Bytes issued in cycles t+1..t+n.
  - LSB_done in cycle t+n+1.
- Each IO-stall cycle adds one cycle.
- The done cycle D is not IDLE. The controller is in IDLE in cycle D+1.
- Minimum turnaround: one idle cycle between transactions.
- Requesters update req at the edge ending cycle D.

## Structure
- `define.v` holds:
  - state encodings ST_IDLE, ST_IF_RD, ST_LS_RD, ST_LS_WR
  - LEN_B, LEN_H, LEN_W
  - IO_BASE and IO_MASK
- Single module, no sub-module. Byte steering is a `cnt`-indexed part-select.

## Test plan
- IF only, addr 0x100, RAM bytes 13 05 00 00 → IF_inst = 32'h00000513 with IF_done in cycle t+6; mem_a steps 0x100..0x103.
- Simultaneous IF_req and LSB_req from reset → LSB is served first, then IF. With both held continuously, grants alternate LSB, IF, LSB.
- Store word 0xDEADBEEF to 0x200 → mem_wr = 1 with bytes EF BE AD DE at 0x200..0x203; LSB_done in cycle t+5. Then a halfword load from 0x202 → LSB_rdata = 0x0000DEAD.
- Byte store to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for those 3 cycles, the byte issues on the 4th, and LSB_done is 3 cycles later than the unstalled case.
- roll at cnt = 2 of a fetch → no IF_done, IDLE next cycle, mem_wr = 0. roll at cnt = 1 of a word store → all 4 bytes are still written and LSB_done pulses.
- rst_n pulled low mid-load, asynchronously between edges → all outputs take reset values immediately. After release, a fresh request completes with correct data.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM port controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StIfRd = 2'd1,
        StLsRd = 2'd2,
        StLsWr = 2'd3
    } state_e;

    typedef enum logic {
        GrantIf  = 1'b0,
        GrantLsb = 1'b1
    } grant_e;

    localparam logic [1:0]  LEN_B   = 2'b00;
    localparam logic [1:0]  LEN_H   = 2'b01;
    localparam logic [1:0]  LEN_W   = 2'b11;
    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam logic [31:0] IO_MASK = 32'hFFFF_0000;

    function automatic logic is_io(input logic [31:0] addr);
        return (addr & IO_MASK) == IO_BASE;
    endfunction

    // The illegal encoding 2'b10 is treated as a single byte.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            LEN_W:   n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbiter and byte sequencer sharing the single byte-wide RAM port between
// instruction fetch and the load/store buffer.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        roll,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        IF_req,
    input  logic [31:0] IF_addr,
    output logic        IF_done,
    output logic [31:0] IF_inst,
    input  logic        LSB_req,
    input  logic        LSB_wr,
    input  logic [1:0]  LSB_len,
    input  logic [31:0] LSB_addr,
    input  logic [31:0] LSB_data,
    output logic        LSB_done,
    output logic [31:0] LSB_rdata
);

    state_e      state_q, state_d;
    grant_e      last_grant_q, last_grant_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic        lsb_done_q, lsb_done_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic        if_ok, lsb_ok, grant_lsb, wr_stall;
    logic [2:0]  n_bytes;
    logic [1:0]  cap_sel, wr_sel;
    logic [31:0] captured;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rbuf_d       = rbuf_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = 1'b0;
        if_done_d    = 1'b0;
        lsb_done_d   = 1'b0;
        if_inst_d    = if_inst_q;
        lsb_rdata_d  = lsb_rdata_q;

        // A flush cancels fetches and loads being requested, but stores are committed.
        if_ok     = IF_req && !roll;
        lsb_ok    = LSB_req && !(roll && !LSB_wr);
        grant_lsb = lsb_ok && (!if_ok || last_grant_q == GrantIf);
        wr_stall  = is_io(LSB_addr) && io_buffer_full;
        n_bytes   = (state_q == StIfRd) ? 3'd4 : len_bytes(LSB_len);

        // Byte for address cnt-1 arrives from the RAM while cnt is being driven.
        cap_sel   = cnt_q[1:0] - 2'd1;
        wr_sel    = cnt_q[1:0] + 2'd1;
        captured  = rbuf_q;
        captured[{cap_sel, 3'b000} +: 8] = mem_din;

        unique case (state_q)
            StIdle: begin
                if (grant_lsb) begin
                    last_grant_d = GrantLsb;
                    cnt_d        = 3'd0;
                    rbuf_d       = 32'd0;
                    mem_a_d      = LSB_addr;
                    if (LSB_wr) begin
                        state_d    = StLsWr;
                        mem_dout_d = LSB_data[7:0];
                        mem_wr_d   = !wr_stall;
                    end else begin
                        state_d    = StLsRd;
                    end
                end else if (if_ok) begin
                    last_grant_d = GrantIf;
                    state_d      = StIfRd;
                    cnt_d        = 3'd0;
                    rbuf_d       = 32'd0;
                    mem_a_d      = IF_addr;
                end
            end
            StIfRd, StLsRd: begin
                if (if_done_q || lsb_done_q) begin
                    state_d = StIdle;
                end else if (roll) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q != 3'd0) begin
                        rbuf_d = captured;
                    end
                    if (cnt_q + 3'd1 < n_bytes) begin
                        mem_a_d = mem_a_q + 32'd1;
                    end
                    if (cnt_q == n_bytes) begin
                        cnt_d = 3'd0;
                        if (state_q == StIfRd) begin
                            if_done_d = 1'b1;
                            if_inst_d = captured;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = captured;
                        end
                    end
                end
            end
            StLsWr: begin
                if (lsb_done_q) begin
                    state_d = StIdle;
                end else if (mem_wr_q) begin
                    if (cnt_q == n_bytes - 3'd1) begin
                        lsb_done_d = 1'b1;
                        cnt_d      = 3'd0;
                    end else begin
                        cnt_d      = cnt_q + 3'd1;
                        mem_a_d    = mem_a_q + 32'd1;
                        mem_dout_d = LSB_data[{wr_sel, 3'b000} +: 8];
                        mem_wr_d   = !wr_stall;
                    end
                end else begin
                    // Byte held back by the IO buffer; retry without advancing.
                    mem_wr_d = !wr_stall;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= GrantIf;
            cnt_q        <= 3'd0;
            rbuf_q       <= 32'd0;
            mem_a_q      <= 32'd0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
            if_done_q    <= 1'b0;
            lsb_done_q   <= 1'b0;
            if_inst_q    <= 32'd0;
            lsb_rdata_q  <= 32'd0;
        end else if (rdy) begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rbuf_q       <= rbuf_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            if_done_q    <= if_done_d;
            lsb_done_q   <= lsb_done_d;
            if_inst_q    <= if_inst_d;
            lsb_rdata_q  <= lsb_rdata_d;
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign IF_done   = if_done_q;
    assign IF_inst   = if_inst_q;
    assign LSB_done  = lsb_done_q;
    assign LSB_rdata = lsb_rdata_q;

endmodule
